// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-outstanding Wishbone pipelined command master
module wb_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [3:0]            cmd_sel_i,
  input  logic [31:0]           cmd_dat_i,
  output logic                  rsp_valid_o,
  output logic [1:0]            rsp_status_o,
  output logic [31:0]           rsp_dat_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i,
  input  logic [31:0]           wb_dat_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_BACKOFF = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam logic [1:0]  ST_OK    = 2'b00;
  localparam logic [1:0]  ST_ERR   = 2'b01;
  localparam logic [1:0]  ST_RTY   = 2'b10;
  localparam logic [1:0]  ST_TMO   = 2'b11;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  RTY_MAX  = 8'(MAX_RETRY);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [15:0]             r_tmo_cnt;
  logic [7:0]              r_retry_cnt;
  logic                    r_wb_we;
  logic [ADDR_WIDTH-1:0]   r_wb_adr;
  logic [3:0]              r_wb_sel;
  logic [31:0]             r_wb_dat;
  logic [1:0]              r_rsp_status;
  logic [31:0]             r_rsp_dat;

  logic                    w_active;
  logic                    w_term;
  logic                    w_tmo_hit;
  logic                    w_latch;
  logic                    w_done;
  logic                    w_retry;
  logic [1:0]              w_status;
  logic                    w_cap_dat;
  logic                    w_clr_dat;

  // Bus cycle is live only in REQ/WAIT, so reset drops cyc/stb through the state register.
  assign w_active  = (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_term    = wb_err_i | wb_ack_i | wb_rty_i;
  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

  assign cmd_ready_o  = (r_state == S_IDLE);
  assign rsp_valid_o  = (r_state == S_RESP);
  assign wb_cyc_o     = w_active;
  assign wb_stb_o     = (r_state == S_REQ);
  assign wb_we_o      = r_wb_we;
  assign wb_adr_o     = r_wb_adr;
  assign wb_sel_o     = r_wb_sel;
  assign wb_dat_o     = r_wb_dat;
  assign rsp_status_o = r_rsp_status;
  assign rsp_dat_o    = r_rsp_dat;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and termination decode; err beats ack beats rty beats timeout
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_done      = 1'b0;
    w_retry     = 1'b0;
    w_status    = ST_OK;
    w_cap_dat   = 1'b0;
    w_clr_dat   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          w_latch     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        if (wb_err_i) begin
          w_done   = 1'b1;
          w_status = ST_ERR;
        end else if (wb_ack_i) begin
          w_done   = 1'b1;
          w_status = ST_OK;
          if (r_wb_we) begin
            w_clr_dat = 1'b1;
          end else begin
            w_cap_dat = 1'b1;
          end
        end else if (wb_rty_i) begin
          if (r_retry_cnt < RTY_MAX) begin
            w_retry = 1'b1;
          end else begin
            w_done   = 1'b1;
            w_status = ST_RTY;
          end
        end else if (w_tmo_hit) begin
          w_done   = 1'b1;
          w_status = ST_TMO;
        end else if ((r_state == S_REQ) && !wb_stall_i) begin
          w_state_nxt = S_WAIT;
        end
        if (w_done) begin
          w_state_nxt = S_RESP;
        end else if (w_retry) begin
          w_state_nxt = S_BACKOFF;
        end
      end
      S_BACKOFF: w_state_nxt = S_REQ;
      S_RESP:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Per-attempt timeout counter, restarted whenever REQ is entered
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tmo_cnt <= '0;
    end else if (w_latch || (r_state == S_BACKOFF)) begin
      r_tmo_cnt <= '0;
    end else if (w_active && !w_term) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  // Latched command and retry count, held across re-issues
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wb_we     <= 1'b0;
      r_wb_adr    <= '0;
      r_wb_sel    <= '0;
      r_wb_dat    <= '0;
      r_retry_cnt <= '0;
    end else if (w_latch) begin
      r_wb_we     <= cmd_we_i;
      r_wb_adr    <= cmd_adr_i;
      r_wb_sel    <= cmd_sel_i;
      r_wb_dat    <= cmd_dat_i;
      r_retry_cnt <= '0;
    end else if (w_retry) begin
      r_retry_cnt <= r_retry_cnt + 8'd1;
    end
  end

  // Response status and data; data only moves on an ack, so err/rty/timeout leave it intact
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rsp_status <= ST_OK;
      r_rsp_dat    <= '0;
    end else if (w_done) begin
      r_rsp_status <= w_status;
      if (w_cap_dat) begin
        r_rsp_dat <= wb_dat_i;
      end else if (w_clr_dat) begin
        r_rsp_dat <= '0;
      end
    end
  end

endmodule
